// File: rtl/boa_sram_pkg.sv
// Shared types and constants for the boa external 16-bit asynchronous SRAM controller.
package boa_sram_pkg;

  localparam int SRAM_WAIT_BITS = 4;

  typedef logic [SRAM_WAIT_BITS-1:0] wait_cnt_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    HOLD   = 3'd3,
    TURN   = 3'd4,
    DONE   = 3'd5
  } sram_state_t;

  // Active-low {ub_n, lb_n} for one 16-bit half; reads always enable both bytes.
  function automatic logic [1:0] lane_n(input logic is_wr, input logic [1:0] we_half);
    logic [1:0] lanes;
    if (is_wr) begin
      lanes = ~we_half;
    end else begin
      lanes = 2'b00;
    end
    return lanes;
  endfunction

endpackage

// File: rtl/boa_sram16_ctrl.sv
// Splits each 32-bit bus access into one or two 16-bit asynchronous SRAM cycles with
// programmable strobe wait states, byte-lane strobes and a write-to-read turnaround.
module boa_sram16_ctrl
  import boa_sram_pkg::*;
#(
  parameter int alen    = 16,
  parameter int wait_rd = 2,
  parameter int wait_wr = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            bus_re,
  input  logic [3:0]      bus_we,
  input  logic [alen-1:0] bus_addr,
  input  logic [31:0]     bus_wdata,
  output logic [31:0]     bus_rdata,
  output logic            bus_ready,
  output logic [alen-2:0] sram_a,
  output logic [15:0]     sram_dq_o,
  input  logic [15:0]     sram_dq_i,
  output logic            sram_dq_oe,
  output logic            sram_ce_n,
  output logic            sram_oe_n,
  output logic            sram_we_n,
  output logic            sram_lb_n,
  output logic            sram_ub_n
);

  localparam wait_cnt_t RD_WAIT = wait_cnt_t'(wait_rd);
  localparam wait_cnt_t WR_WAIT = wait_cnt_t'(wait_wr);

  sram_state_t     state_r;
  wait_cnt_t       cnt_r;
  logic            half_r;
  logic            is_wr_r;
  logic            prev_wr_r;
  logic [3:0]      we_r;

  logic            req_wr_s;
  logic            req_rd_s;
  logic            setup_half_s;
  logic            setup_wr_s;
  logic [3:0]      setup_we_s;
  logic [1:0]      setup_lanes_s;
  logic [alen-2:0] setup_a_s;
  logic [15:0]     setup_dq_s;
  logic            unused_s;

  assign unused_s = ^bus_addr[1:0];
  assign req_wr_s = (bus_we != 4'b0000);
  assign req_rd_s = bus_re && !req_wr_s;

  // Address, lanes and data for the half presented by the next SETUP cycle
  always_comb begin
    if (state_r == IDLE) begin
      setup_half_s = req_wr_s && (bus_we[1:0] == 2'b00);
      setup_wr_s   = req_wr_s;
      setup_we_s   = bus_we;
    end else begin
      setup_half_s = (state_r == STROBE) || (state_r == HOLD);
      setup_wr_s   = is_wr_r;
      setup_we_s   = we_r;
    end
    setup_a_s     = {bus_addr[alen-1:2], setup_half_s};
    setup_lanes_s = lane_n(setup_wr_s, setup_half_s ? setup_we_s[3:2] : setup_we_s[1:0]);
    setup_dq_s    = setup_half_s ? bus_wdata[31:16] : bus_wdata[15:0];
  end

  // Access sequencer; every SRAM pin and bus response is registered here
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      cnt_r      <= wait_cnt_t'(0);
      half_r     <= 1'b0;
      is_wr_r    <= 1'b0;
      prev_wr_r  <= 1'b0;
      we_r       <= 4'b0000;
      bus_rdata  <= 32'h0000_0000;
      bus_ready  <= 1'b0;
      sram_a     <= {(alen-1){1'b0}};
      sram_dq_o  <= 16'h0000;
      sram_dq_oe <= 1'b0;
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_lb_n  <= 1'b1;
      sram_ub_n  <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          bus_ready <= 1'b0;
          if (req_wr_s || req_rd_s) begin
            is_wr_r   <= req_wr_s;
            we_r      <= bus_we;
            prev_wr_r <= req_wr_s;
            if (req_rd_s && prev_wr_r) begin
              // Give the pads a cycle to release the bus before the SRAM drives it
              state_r    <= TURN;
              half_r     <= 1'b0;
              sram_ce_n  <= 1'b1;
              sram_dq_oe <= 1'b0;
            end else begin
              state_r                <= SETUP;
              half_r                 <= setup_half_s;
              sram_a                 <= setup_a_s;
              {sram_ub_n, sram_lb_n} <= setup_lanes_s;
              sram_dq_o              <= setup_dq_s;
              sram_dq_oe             <= setup_wr_s;
              sram_ce_n              <= 1'b0;
            end
          end else begin
            state_r <= IDLE;
          end
        end

        TURN: begin
          state_r                <= SETUP;
          half_r                 <= setup_half_s;
          sram_a                 <= setup_a_s;
          {sram_ub_n, sram_lb_n} <= setup_lanes_s;
          sram_dq_o              <= setup_dq_s;
          sram_dq_oe             <= setup_wr_s;
          sram_ce_n              <= 1'b0;
        end

        SETUP: begin
          state_r   <= STROBE;
          cnt_r     <= is_wr_r ? WR_WAIT : RD_WAIT;
          sram_oe_n <= is_wr_r;
          sram_we_n <= !is_wr_r;
        end

        STROBE: begin
          if (cnt_r != wait_cnt_t'(0)) begin
            cnt_r <= cnt_r - wait_cnt_t'(1);
          end else begin
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
            if (is_wr_r) begin
              state_r <= HOLD;
            end else begin
              if (half_r) begin
                bus_rdata[31:16] <= sram_dq_i;
              end else begin
                bus_rdata[15:0]  <= sram_dq_i;
              end
              if (!half_r) begin
                state_r                <= SETUP;
                half_r                 <= setup_half_s;
                sram_a                 <= setup_a_s;
                {sram_ub_n, sram_lb_n} <= setup_lanes_s;
                sram_dq_o              <= setup_dq_s;
                sram_dq_oe             <= setup_wr_s;
              end else begin
                state_r    <= DONE;
                bus_ready  <= 1'b1;
                sram_ce_n  <= 1'b1;
                sram_dq_oe <= 1'b0;
                sram_lb_n  <= 1'b1;
                sram_ub_n  <= 1'b1;
              end
            end
          end
        end

        HOLD: begin
          if (!half_r && (we_r[3:2] != 2'b00)) begin
            state_r                <= SETUP;
            half_r                 <= setup_half_s;
            sram_a                 <= setup_a_s;
            {sram_ub_n, sram_lb_n} <= setup_lanes_s;
            sram_dq_o              <= setup_dq_s;
            sram_dq_oe             <= setup_wr_s;
          end else begin
            state_r    <= DONE;
            bus_ready  <= 1'b1;
            sram_ce_n  <= 1'b1;
            sram_dq_oe <= 1'b0;
            sram_lb_n  <= 1'b1;
            sram_ub_n  <= 1'b1;
          end
        end

        DONE: begin
          state_r   <= IDLE;
          bus_ready <= 1'b0;
        end

        default: begin
          state_r    <= IDLE;
          bus_ready  <= 1'b0;
          sram_ce_n  <= 1'b1;
          sram_oe_n  <= 1'b1;
          sram_we_n  <= 1'b1;
          sram_dq_oe <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_boa_sram16_ctrl.sv
// Two controllers (waits 2/2 and 0/3) behind behavioural SRAMs, checked against a
// word-level memory model with latencies computed from the access-size rules.
module tb_boa_sram16_ctrl;

  localparam int MW = 32768;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_init = 1'b0;

  logic        re_v    [2];
  logic [3:0]  we_v    [2];
  logic [15:0] addr_v  [2];
  logic [31:0] wdata_v [2];
  logic [31:0] rdata_v [2];
  logic        ready_v [2];
  logic [14:0] a_v     [2];
  logic [15:0] dq_o_v  [2];
  logic [15:0] dq_i_v  [2];
  logic        dq_oe_v [2];
  logic        ce_n_v  [2];
  logic        oe_n_v  [2];
  logic        we_n_v  [2];
  logic        lb_n_v  [2];
  logic        ub_n_v  [2];

  logic [15:0] sram_mem [2][MW];
  logic [15:0] ref_mem  [2][MW];
  logic [14:0] a_prev_v [2];
  logic        rdy_prev_v [2];
  int          oe_low_v [2];
  int          we_low_v [2];
  int          prot_err = 0;

  int          n_assert = 0;
  int          n_fail = 0;
  bit          prev_wr [2];
  logic [31:0] last_rd [2];
  bit          just_done = 1'b0;
  int          last_sel = 0;

  always #5 clk = ~clk;

  boa_sram16_ctrl #(.alen(16), .wait_rd(2), .wait_wr(2)) dut0 (
    .clk(clk), .rst(rst), .bus_re(re_v[0]), .bus_we(we_v[0]), .bus_addr(addr_v[0]),
    .bus_wdata(wdata_v[0]), .bus_rdata(rdata_v[0]), .bus_ready(ready_v[0]),
    .sram_a(a_v[0]), .sram_dq_o(dq_o_v[0]), .sram_dq_i(dq_i_v[0]), .sram_dq_oe(dq_oe_v[0]),
    .sram_ce_n(ce_n_v[0]), .sram_oe_n(oe_n_v[0]), .sram_we_n(we_n_v[0]),
    .sram_lb_n(lb_n_v[0]), .sram_ub_n(ub_n_v[0]));

  boa_sram16_ctrl #(.alen(16), .wait_rd(0), .wait_wr(3)) dut1 (
    .clk(clk), .rst(rst), .bus_re(re_v[1]), .bus_we(we_v[1]), .bus_addr(addr_v[1]),
    .bus_wdata(wdata_v[1]), .bus_rdata(rdata_v[1]), .bus_ready(ready_v[1]),
    .sram_a(a_v[1]), .sram_dq_o(dq_o_v[1]), .sram_dq_i(dq_i_v[1]), .sram_dq_oe(dq_oe_v[1]),
    .sram_ce_n(ce_n_v[1]), .sram_oe_n(oe_n_v[1]), .sram_we_n(we_n_v[1]),
    .sram_lb_n(lb_n_v[1]), .sram_ub_n(ub_n_v[1]));

  function automatic int rd_wait(input int s);
    return (s == 0) ? 2 : 0;
  endfunction

  function automatic int wr_wait(input int s);
    return (s == 0) ? 2 : 3;
  endfunction

  function automatic logic [15:0] init_word(input int s, input int i);
    return 16'((i * 40503) ^ (s * 21845) ^ (i >> 5));
  endfunction

  function automatic bit viol(input int g);
    return (dq_oe_v[g] && !oe_n_v[g]) || (!we_n_v[g] && (a_v[g] != a_prev_v[g])) ||
           (ready_v[g] && rdy_prev_v[g]) || (!we_n_v[g] && !dq_oe_v[g]) ||
           (!oe_n_v[g] && ce_n_v[g]) || (!we_n_v[g] && ce_n_v[g]);
  endfunction

  // Read data is only driven while chip and output enables are both low
  always_comb begin
    for (int g = 0; g < 2; g++) begin
      dq_i_v[g] = (!ce_n_v[g] && !oe_n_v[g]) ? sram_mem[g][a_v[g]] : 16'hdead;
    end
  end

  // SRAM array: byte-lane writes while we_n is low; undriven pads store garbage
  always @(posedge clk) begin
    if (mem_init) begin
      for (int g = 0; g < 2; g++) begin
        for (int i = 0; i < MW; i++) begin
          sram_mem[g][i] <= init_word(g, i);
        end
      end
    end else begin
      for (int g = 0; g < 2; g++) begin
        if (!ce_n_v[g] && !we_n_v[g]) begin
          if (!lb_n_v[g]) sram_mem[g][a_v[g]][7:0] <= dq_oe_v[g] ? dq_o_v[g][7:0] : 8'h5a;
          if (!ub_n_v[g]) sram_mem[g][a_v[g]][15:8] <= dq_oe_v[g] ? dq_o_v[g][15:8] : 8'ha5;
        end
      end
    end
  end

  // Pin-level protocol monitor and strobe-cycle counters
  always @(negedge clk) begin
    if (viol(0) || viol(1)) prot_err <= prot_err + 1;
    for (int g = 0; g < 2; g++) begin
      a_prev_v[g]   <= a_v[g];
      rdy_prev_v[g] <= ready_v[g];
      oe_low_v[g]   <= oe_low_v[g] + (oe_n_v[g] ? 0 : 1);
      we_low_v[g]   <= we_low_v[g] + (we_n_v[g] ? 0 : 1);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic access(input int sel, input logic [3:0] we, input logic [15:0] addr,
                        input logic [31:0] wdata, input int gap);
    bit          wr;
    int          halves, lat_exp, n, oe0, we0, wb;
    logic [31:0] exp_rd;
    wr = (we != 4'b0000);
    repeat (gap) @(negedge clk);
    wb = int'({addr[15:2], 1'b0});
    halves = int'(we[1:0] != 2'b00) + int'(we[3:2] != 2'b00);
    if (wr) begin
      lat_exp = (halves == 2) ? 2 * wr_wait(sel) + 7 : wr_wait(sel) + 4;
      for (int b = 0; b < 4; b++) begin
        if (we[b]) ref_mem[sel][wb + b / 2][8 * (b % 2) +: 8] = wdata[8 * b +: 8];
      end
      exp_rd = last_rd[sel];
    end else begin
      lat_exp = 2 * rd_wait(sel) + 5 + (prev_wr[sel] ? 1 : 0);
      exp_rd = {ref_mem[sel][wb + 1], ref_mem[sel][wb]};
    end
    if (gap == 0 && just_done && last_sel == sel) lat_exp++;
    oe0 = oe_low_v[sel];
    we0 = we_low_v[sel];
    re_v[sel]    = wr ? 1'($urandom_range(0, 1)) : 1'b1;
    we_v[sel]    = we;
    addr_v[sel]  = addr;
    wdata_v[sel] = wdata;
    n = 0;
    while (n < 100) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (ready_v[sel]) break;
    end
    re_v[sel] = 1'b0;
    we_v[sel] = 4'b0000;
    check("latency", n, lat_exp);
    check("rdata", rdata_v[sel], exp_rd);
    check("oe_low_cycles", oe_low_v[sel] - oe0, wr ? 0 : 2 * (rd_wait(sel) + 1));
    check("we_low_cycles", we_low_v[sel] - we0, wr ? halves * (wr_wait(sel) + 1) : 0);
    if (wr) begin
      check("mem_lo", sram_mem[sel][wb], ref_mem[sel][wb]);
      check("mem_hi", sram_mem[sel][wb + 1], ref_mem[sel][wb + 1]);
    end else begin
      last_rd[sel] = exp_rd;
    end
    prev_wr[sel] = wr;
    just_done = 1'b1;
    last_sel = sel;
  endtask

  initial begin
    int          s, gap, n;
    logic [3:0]  w;
    for (int g = 0; g < 2; g++) begin
      re_v[g] = 1'b0; we_v[g] = 4'b0000; addr_v[g] = 16'h0000; wdata_v[g] = 32'h0;
      prev_wr[g] = 1'b0; last_rd[g] = 32'h0;
      for (int i = 0; i < MW; i++) ref_mem[g][i] = init_word(g, i);
    end
    mem_init = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mem_init = 1'b0;
    repeat (2) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      check("rst_ctl", {ce_n_v[g], oe_n_v[g], we_n_v[g], lb_n_v[g], ub_n_v[g], dq_oe_v[g],
                        ready_v[g]}, 32'h0000_007c);
      check("rst_rdata", rdata_v[g], 32'h0);
      check("rst_addr_dq", {a_v[g], dq_o_v[g]}, 32'h0);
    end
    rst = 1'b1;

    // Directed accesses on the 2/2-wait controller around words 8 and 9
    access(0, 4'b1111, 16'h0010, 32'habcd1234, 1);
    access(0, 4'b0000, 16'h0010, 32'h0, 0);
    access(0, 4'b0000, 16'h0013, 32'h0, 1);
    check("tp_read", rdata_v[0], 32'habcd1234);
    access(0, 4'b1111, 16'h0010, 32'hdeadbeef, 1);
    access(0, 4'b0100, 16'h0010, 32'h00aa0000, 1);
    check("tp_byte_w9", sram_mem[0][9], 16'hdeaa);
    access(0, 4'b0000, 16'h0010, 32'h0, 1);
    check("tp_readback", rdata_v[0], 32'hdeaabeef);

    // Reset in the middle of a write strobe abandons it immediately
    @(negedge clk);
    just_done = 1'b0;
    we_v[0] = 4'b1111; addr_v[0] = 16'h0100; wdata_v[0] = 32'h13572468;
    n = 0;
    while (we_n_v[0] && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rst_reach_strobe", we_n_v[0], 1'b0);
    #1 rst = 1'b0;
    #1;
    check("rst_mid_ctl", {we_n_v[0], dq_oe_v[0], ready_v[0], ce_n_v[0]}, 32'h9);
    we_v[0] = 4'b0000;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    check("rst_mid_rdata", rdata_v[0], 32'h0);
    for (int g = 0; g < 2; g++) begin
      prev_wr[g] = 1'b0;
      last_rd[g] = 32'h0;
    end
    access(0, 4'b0000, 16'h0010, 32'h0, 1);
    check("post_rst_read", rdata_v[0], 32'hdeaabeef);

    // Back-to-back zero-wait reads
    access(1, 4'b0000, 16'h0200, 32'h0, 1);
    for (int k = 0; k < 3; k++) begin
      access(1, 4'b0000, 16'(16'h0204 + 16'(4 * k)), 32'h0, 0);
    end

    // Random mix of reads and partial writes on both controllers
    for (int k = 0; k < 80; k++) begin
      s = $urandom_range(0, 1);
      gap = $urandom_range(0, 2);
      if ($urandom_range(0, 2) == 0) begin
        w = 4'b0000;
      end else begin
        w = 4'($urandom_range(1, 15));
      end
      access(s, w, 16'({$urandom_range(0, 15), 2'($urandom_range(0, 3))} << 2 ^
                       $urandom_range(0, 3)), $urandom, gap);
    end

    repeat (3) @(negedge clk);
    check("protocol_violations", prot_err, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
